// File: rtl/gba_cart_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : gba_cart_pkg                                                     |
// | Shared types and constants for the cartridge read responder: FSM state     |
// | encoding, core bus-size encoding, cartridge region bounds and the          |
// | open-bus word helper.                                                      |
// | Optional feature macro: CART_PREFETCH_EN (adds the PREFETCH state).        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package gba_cart_pkg;

  localparam logic [31:0] CART_BASE = 32'h0800_0000;
  localparam logic [31:0] CART_END  = 32'h0DFF_FFFF;

`ifdef CART_PREFETCH_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    PREFETCH = 2'd3
  } cart_state_e;
`else
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2
  } cart_state_e;
`endif

  typedef enum logic [1:0] {
    BUS_BYTE = 2'd0,
    BUS_HALF = 2'd1,
    BUS_WORD = 2'd2
  } cart_bus_size_e;

  // Open bus on the cartridge returns the halfword address itself on the
  // data lines; a word read sees the even halfword address and its successor.
  function automatic logic [31:0] open_bus_word(input logic [15:0] hw_addr);
    logic [15:0] h;
    h = {hw_addr[15:1], 1'b0};
    return {h + 16'd1, h};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gba_cart_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : gba_cart_responder_if                                          |
// | Bundles the core-side cartridge read bus and the external 16-bit ROM       |
// | request/acknowledge bus.                                                   |
// |   core side : cart_rd, ext_bus_addr, cart_bus_size -> cart_data, cart_wait |
// |   mem side  : mem_req, mem_addr -> mem_ack, mem_rdata                      |
// | Modports: slave = responder, master = core + memory bridge.                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface gba_cart_responder_if #(
  parameter int ROM_ADDR_W = 25
);
  import gba_cart_pkg::*;

  logic                  cart_rd;
  logic [31:0]           ext_bus_addr;
  cart_bus_size_e        cart_bus_size;
  logic [31:0]           cart_data;
  logic                  cart_wait;

  logic                  mem_req;
  logic [ROM_ADDR_W-2:0] mem_addr;
  logic                  mem_ack;
  logic [15:0]           mem_rdata;

  modport slave (
    input  cart_rd, ext_bus_addr, cart_bus_size, mem_ack, mem_rdata,
    output cart_data, cart_wait, mem_req, mem_addr
  );

  modport master (
    output cart_rd, ext_bus_addr, cart_bus_size, mem_ack, mem_rdata,
    input  cart_data, cart_wait, mem_req, mem_addr
  );

endinterface
`default_nettype wire

// File: rtl/gba_cart_responder_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : cart_word_buffer                                                  |
// | One cached 32-bit ROM word with its word address, valid flag and an        |
// | address comparator.                                                        |
// | Ports: clk, rst_b (async active-low), i_load/i_load_addr/i_load_data       |
// |        (write entry, sets valid), i_invalidate (clear valid), i_cmp_addr   |
// |        -> o_hit; o_valid/o_addr/o_data expose the entry.                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module cart_word_buffer #(
  parameter int WADDR_W = 23
) (
  input  wire logic               clk,
  input  wire logic               rst_b,
  input  wire logic               i_load,
  input  wire logic [WADDR_W-1:0] i_load_addr,
  input  wire logic [31:0]        i_load_data,
  input  wire logic               i_invalidate,
  input  wire logic [WADDR_W-1:0] i_cmp_addr,
  output logic                    o_valid,
  output logic [WADDR_W-1:0]      o_addr,
  output logic [31:0]             o_data,
  output logic                    o_hit
);

  logic               r_valid;
  logic [WADDR_W-1:0] r_addr;
  logic [31:0]        r_data;

  // A load takes priority over an invalidate in the same cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_load_addr;
      r_data  <= i_load_data;
    end else if (i_invalidate) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_hit   = r_valid && (r_addr == i_cmp_addr);

endmodule
`default_nettype wire

// File: rtl/gba_cart_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : gba_cart_responder                                                |
// | Responder for the core's cartridge read bus. Misses stall the core with    |
// | cart_wait while the word is fetched from 16-bit external ROM (low half     |
// | first) over a req/ack handshake; the last word is cached so repeated reads |
// | return without a memory transaction. Offsets >= ROM_SIZE return open bus.  |
// | Ports: clk, rst_b (async active-low), bus (gba_cart_responder_if.slave).   |
// | Parameters: ROM_ADDR_W (byte address width), ROM_SIZE (loaded bytes).      |
// | Optional feature macro: CART_PREFETCH_EN - second buffer holding the next  |
// |   sequential word, fetched while idle after each fill.                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module gba_cart_responder
  import gba_cart_pkg::*;
#(
  parameter int          ROM_ADDR_W = 25,
  parameter logic [31:0] ROM_SIZE   = 32'h0200_0000
) (
  input wire logic            clk,
  input wire logic            rst_b,
  gba_cart_responder_if.slave bus
);

  localparam int c_waddr_w = ROM_ADDR_W - 2;

  // ---------------------------------------------------------------- decode
  // The three wait-state mirrors differ only above ROM_ADDR_W, so they all
  // alias onto the same offset.
  logic [ROM_ADDR_W-1:0] w_offset;
  logic [c_waddr_w-1:0]  w_waddr;
  logic                  w_open_bus;
  logic                  w_main_hit;
  logic                  w_demand_miss;

  assign w_offset   = bus.ext_bus_addr[ROM_ADDR_W-1:0];
  assign w_waddr    = w_offset[ROM_ADDR_W-1:2];
  assign w_open_bus = 33'(w_offset) >= 33'(ROM_SIZE);

  // ------------------------------------------------------------ FSM state
  cart_state_e           r_state;
  cart_state_e           w_state_nxt;
  logic                  r_mem_req;
  logic                  w_mem_req_nxt;
  logic [ROM_ADDR_W-2:0] r_mem_addr;
  logic [ROM_ADDR_W-2:0] w_mem_addr_nxt;
  logic [15:0]           r_lo;
  logic [15:0]           w_lo_nxt;
  logic [c_waddr_w-1:0]  w_fetch_waddr;

  // The word being fetched is carried in the halfword address register, so
  // an address change from the core mid-fetch cannot corrupt the fill.
  assign w_fetch_waddr = r_mem_addr[ROM_ADDR_W-2:1];

  // ---------------------------------------------------------- main buffer
  logic                 w_main_load;
  logic [c_waddr_w-1:0] w_main_load_addr;
  logic [31:0]          w_main_load_data;
  logic                 w_main_valid;
  logic [c_waddr_w-1:0] w_main_addr;
  logic [31:0]          w_main_data;

`ifdef CART_PREFETCH_EN
  logic                 w_pf_load;
  logic                 w_pf_invalidate;
  logic                 w_pf_valid;
  logic [c_waddr_w-1:0] w_pf_addr;
  logic [31:0]          w_pf_data;
  logic                 w_pf_hit;
  logic                 r_pf_pending;
  logic                 w_pf_pending_nxt;
  logic [c_waddr_w-1:0] w_pf_target;
  logic                 w_pf_in_range;
  logic                 w_pf_has_target;
  logic                 w_demand_is_pf;
`endif

  cart_word_buffer #(
    .WADDR_W (c_waddr_w)
  ) u_main_buf (
    .clk          (clk),
    .rst_b        (rst_b),
    .i_load       (w_main_load),
    .i_load_addr  (w_main_load_addr),
    .i_load_data  (w_main_load_data),
    .i_invalidate (1'b0),
    .i_cmp_addr   (w_waddr),
    .o_valid      (w_main_valid),
    .o_addr       (w_main_addr),
    .o_data       (w_main_data),
    .o_hit        (w_main_hit)
  );

`ifdef CART_PREFETCH_EN
  cart_word_buffer #(
    .WADDR_W (c_waddr_w)
  ) u_pf_buf (
    .clk          (clk),
    .rst_b        (rst_b),
    .i_load       (w_pf_load),
    .i_load_addr  (w_fetch_waddr),
    .i_load_data  ({bus.mem_rdata, r_lo}),
    .i_invalidate (w_pf_invalidate),
    .i_cmp_addr   (w_waddr),
    .o_valid      (w_pf_valid),
    .o_addr       (w_pf_addr),
    .o_data       (w_pf_data),
    .o_hit        (w_pf_hit)
  );

  // Next sequential word wraps within the ROM address space; the range check
  // keeps prefetch away from open-bus offsets.
  assign w_pf_target     = w_main_addr + {{(c_waddr_w-1){1'b0}}, 1'b1};
  assign w_pf_in_range   = 33'({w_pf_target, 2'b00}) < 33'(ROM_SIZE);
  assign w_pf_has_target = w_pf_valid && (w_pf_addr == w_pf_target);
  assign w_demand_is_pf  = (w_waddr == w_fetch_waddr);
`endif

  // ----------------------------------------------------------- core side
  assign w_demand_miss = bus.cart_rd && !w_main_hit && !w_open_bus;
  assign bus.cart_wait = w_demand_miss;
  assign bus.cart_data = (bus.cart_rd && w_open_bus && !w_main_hit)
                         ? open_bus_word(w_offset[16:1])
                         : w_main_data;

  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;

  // ------------------------------------------------------ FSM: registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_lo       <= '0;
`ifdef CART_PREFETCH_EN
      r_pf_pending <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_lo       <= w_lo_nxt;
`ifdef CART_PREFETCH_EN
      r_pf_pending <= w_pf_pending_nxt;
`endif
    end
  end

  // ------------------------------------------- FSM: next state / outputs
  // mem_req and mem_addr are produced here as next-state values and only
  // change through the register above, so the bridge always sees them
  // settled for a full cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_mem_req_nxt    = r_mem_req;
    w_mem_addr_nxt   = r_mem_addr;
    w_lo_nxt         = r_lo;
    w_main_load      = 1'b0;
    w_main_load_addr = w_fetch_waddr;
    w_main_load_data = {bus.mem_rdata, r_lo};
`ifdef CART_PREFETCH_EN
    w_pf_load        = 1'b0;
    w_pf_invalidate  = 1'b0;
    w_pf_pending_nxt = r_pf_pending;
`endif

    case (r_state)
      IDLE: begin
        // mem_ack is not looked at here; a stray ack has no effect.
`ifdef CART_PREFETCH_EN
        if (w_demand_miss) begin
          if (w_pf_hit) begin
            // Promote: one stall cycle, then the main buffer hits.
            w_main_load      = 1'b1;
            w_main_load_addr = w_pf_addr;
            w_main_load_data = w_pf_data;
            w_pf_invalidate  = 1'b1;
            w_pf_pending_nxt = 1'b1;
          end else begin
            w_state_nxt    = FETCH_LO;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = {w_waddr, 1'b0};
          end
        end else if (r_pf_pending) begin
          w_pf_pending_nxt = 1'b0;
          if (w_pf_in_range && !w_pf_has_target) begin
            w_state_nxt    = PREFETCH;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = {w_pf_target, 1'b0};
          end
        end
`else
        if (w_demand_miss) begin
          w_state_nxt    = FETCH_LO;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = {w_waddr, 1'b0};
        end
`endif
      end

      FETCH_LO: begin
        if (bus.mem_ack) begin
          w_lo_nxt       = bus.mem_rdata;
          w_mem_addr_nxt = {w_fetch_waddr, 1'b1};
          w_state_nxt    = FETCH_HI;
        end
      end

      FETCH_HI: begin
        if (bus.mem_ack) begin
          w_main_load   = 1'b1;
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IDLE;
`ifdef CART_PREFETCH_EN
          w_pf_pending_nxt = 1'b1;
`endif
        end
      end

`ifdef CART_PREFETCH_EN
      // Both halves of a prefetch live in this state; mem_addr[0] tells
      // which half is outstanding. A demand miss is only acted on at an ack
      // so the bridge never sees a request withdrawn before it is answered.
      PREFETCH: begin
        if (bus.mem_ack) begin
          if (!r_mem_addr[0]) begin
            w_lo_nxt = bus.mem_rdata;
            if (w_demand_miss && !w_demand_is_pf) begin
              w_mem_req_nxt = 1'b0;
              w_state_nxt   = IDLE;
            end else begin
              w_mem_addr_nxt = {w_fetch_waddr, 1'b1};
              w_state_nxt    = w_demand_miss ? FETCH_HI : PREFETCH;
            end
          end else begin
            w_mem_req_nxt = 1'b0;
            w_state_nxt   = IDLE;
            if (w_demand_miss && w_demand_is_pf) begin
              w_main_load      = 1'b1;
              w_pf_pending_nxt = 1'b1;
            end else begin
              w_pf_load = 1'b1;
            end
          end
        end
      end
`endif

      default: begin
        w_state_nxt   = IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // Bus-size is informational (a full word is always returned) and the
  // upper address bits only select the mirror region.
  logic w_unused;
  assign w_unused = ^{bus.ext_bus_addr[31:ROM_ADDR_W], bus.cart_bus_size, w_main_valid};

endmodule
`default_nettype wire

// File: tb/tb_gba_cart_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_gba_cart_responder                                             |
// | Self-checking bench for gba_cart_responder with a small 16-bit ROM model   |
// | answering the req/ack bus with a programmable number of wait cycles.       |
// | Optional feature macro: CART_PREFETCH_EN selects the prefetch scenario.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_gba_cart_responder;
  import gba_cart_pkg::*;

  localparam int          ROM_ADDR_W = 25;
  localparam logic [31:0] ROM_SIZE   = 32'h0000_0100;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;

  gba_cart_responder_if #(.ROM_ADDR_W(ROM_ADDR_W)) bus ();

  gba_cart_responder #(
    .ROM_ADDR_W (ROM_ADDR_W),
    .ROM_SIZE   (ROM_SIZE)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // ------------------------------------------------------- memory model
  logic [15:0]           rom [0:15];
  int                    mem_waits = 0;
  bit                    stray_ack = 1'b0;
  int                    stab_err  = 0;
  logic [ROM_ADDR_W-2:0] ack_log [$];

  initial begin
    int                    wait_cnt;
    logic                  prev_req;
    logic                  prev_ack;
    logic [ROM_ADDR_W-2:0] prev_addr;
    wait_cnt      = 0;
    prev_req      = 1'b0;
    prev_ack      = 1'b0;
    prev_addr     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.mem_req && prev_req && !prev_ack && bus.mem_addr !== prev_addr)
        stab_err++;
      prev_req  = bus.mem_req;
      prev_addr = bus.mem_addr;
      if (bus.mem_req) begin
        if (wait_cnt >= mem_waits) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rom[bus.mem_addr[3:0]];
          ack_log.push_back(bus.mem_addr);
          wait_cnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        wait_cnt      = 0;
        bus.mem_ack   = stray_ack;
        bus.mem_rdata = stray_ack ? 16'hFFFF : 16'h0000;
      end
      prev_ack = bus.mem_ack;
    end
  end

  // ------------------------------------------------------ read transaction
  // Holds cart_rd until cart_wait drops; counts stalled cycles and cycles
  // with mem_req high. A bound of 50 cycles shows up as waits = 50.
  task automatic do_read(input logic [31:0] addr, input cart_bus_size_e size,
                         output int waits, output logic [31:0] data,
                         output int reqs);
    waits = 0;
    reqs  = 0;
    data  = 32'hxxxx_xxxx;
    @(negedge clk);
    bus.cart_rd       = 1'b1;
    bus.ext_bus_addr  = addr;
    bus.cart_bus_size = size;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (bus.mem_req) reqs++;
      if (!bus.cart_wait) begin
        data = bus.cart_data;
        break;
      end
      waits++;
      @(negedge clk);
    end
    bus.cart_rd = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (bus.mem_req !== 1'b0)   $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); else passes++;
    checks++; if (bus.mem_addr !== '0)    $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); else passes++;
    checks++; if (bus.cart_data !== 32'h0) $display("FAIL reset_cart_data: got %h expected 00000000", bus.cart_data); else passes++;
    checks++; if (bus.cart_wait !== 1'b0) $display("FAIL reset_cart_wait: got %b expected 0", bus.cart_wait); else passes++;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_first_read;
    int w, r; logic [31:0] d;
    ack_log.delete();
    do_read(32'h0800_0000, BUS_WORD, w, d, r);
    checks++; if (w !== 3) $display("FAIL first_read_wait: got %0d expected 3", w); else passes++;
    checks++; if (d !== 32'hABCD_1234) $display("FAIL first_read_data: got %h expected abcd1234", d); else passes++;
    checks++; if (r !== 2) $display("FAIL first_read_req_cycles: got %0d expected 2", r); else passes++;
    checks++;
    if (ack_log.size() != 2 || ack_log[0] !== 24'd0 || ack_log[1] !== 24'd1)
      $display("FAIL first_read_mem_addr: got %0d acks first %h expected addresses 0,1", ack_log.size(), ack_log[0]);
    else passes++;
  endtask

  task automatic test_hit;
    int w, r; logic [31:0] d;
    ack_log.delete();
    do_read(32'h0800_0002, BUS_HALF, w, d, r);
    checks++; if (w !== 0) $display("FAIL hit_wait: got %0d expected 0", w); else passes++;
    checks++; if (d !== 32'hABCD_1234) $display("FAIL hit_data: got %h expected abcd1234", d); else passes++;
    do_read(32'h0C00_0000, BUS_WORD, w, d, r);
    checks++; if (w !== 0) $display("FAIL mirror_hit_wait: got %0d expected 0", w); else passes++;
    checks++; if (d !== 32'hABCD_1234) $display("FAIL mirror_hit_data: got %h expected abcd1234", d); else passes++;
    @(negedge clk);
    checks++; if (ack_log.size() != 0) $display("FAIL hit_no_mem_req: got %0d acks expected 0", ack_log.size()); else passes++;
  endtask

  task automatic test_open_bus;
    int w, r; logic [31:0] d;
    do_read(32'h0800_0200, BUS_WORD, w, d, r);
    checks++; if (w !== 0) $display("FAIL open_bus_wait: got %0d expected 0", w); else passes++;
    checks++; if (r !== 0) $display("FAIL open_bus_req: got %0d expected 0", r); else passes++;
    checks++; if (d !== 32'h0101_0100) $display("FAIL open_bus_data: got %h expected 01010100", d); else passes++;
    do_read(32'h0A01_FFFF, BUS_BYTE, w, d, r);
    checks++; if (d !== 32'hFFFF_FFFE) $display("FAIL open_bus_top_data: got %h expected fffffffe", d); else passes++;
    #1;
    checks++; if (bus.cart_data !== 32'hABCD_1234) $display("FAIL open_bus_idle_data: got %h expected abcd1234", bus.cart_data); else passes++;
  endtask

  task automatic test_wait_states;
    int w, r; logic [31:0] d;
    mem_waits = 4;
    stab_err  = 0;
    ack_log.delete();
    do_read(32'h0800_0008, BUS_WORD, w, d, r);
    checks++; if (w !== 11) $display("FAIL wait4_wait: got %0d expected 11", w); else passes++;
    checks++; if (d !== 32'hC0DE_0F0F) $display("FAIL wait4_data: got %h expected c0de0f0f", d); else passes++;
    checks++; if (r !== 10) $display("FAIL wait4_req_cycles: got %0d expected 10", r); else passes++;
    checks++; if (stab_err !== 0) $display("FAIL wait4_addr_stable: got %0d changes expected 0", stab_err); else passes++;
    checks++;
    if (ack_log.size() != 2 || ack_log[0] !== 24'd4 || ack_log[1] !== 24'd5)
      $display("FAIL wait4_mem_addr: got %0d acks first %h expected addresses 4,5", ack_log.size(), ack_log[0]);
    else passes++;
    mem_waits = 0;
  endtask

  task automatic test_drop_rd;
    int w, r; logic [31:0] d;
    mem_waits = 2;
    ack_log.delete();
    @(negedge clk);
    bus.cart_rd      = 1'b1;
    bus.ext_bus_addr = 32'h0800_000C;
    @(negedge clk);
    bus.cart_rd = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (ack_log.size() != 2 || ack_log[0] !== 24'd6 || ack_log[1] !== 24'd7)
      $display("FAIL drop_rd_fetch: got %0d acks first %h expected addresses 6,7", ack_log.size(), ack_log[0]);
    else passes++;
    mem_waits = 0;
    do_read(32'h0800_000C, BUS_WORD, w, d, r);
    checks++; if (w !== 0) $display("FAIL drop_rd_hit_wait: got %0d expected 0", w); else passes++;
    checks++; if (d !== 32'h2222_1111) $display("FAIL drop_rd_hit_data: got %h expected 22221111", d); else passes++;
  endtask

  task automatic test_stray_ack;
    int w, r; logic [31:0] d;
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL stray_ack_req: got %b expected 0", bus.mem_req); else passes++;
    do_read(32'h0800_000C, BUS_WORD, w, d, r);
    checks++; if (d !== 32'h2222_1111) $display("FAIL stray_ack_data: got %h expected 22221111", d); else passes++;
  endtask

  task automatic test_reset_mid_fetch;
    int w, r; logic [31:0] d;
    bit reached;
    reached   = 1'b0;
    mem_waits = 4;
    @(negedge clk);
    bus.cart_rd      = 1'b1;
    bus.ext_bus_addr = 32'h0800_0010;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.mem_req && bus.mem_addr[0]) begin
        reached = 1'b1;
        break;
      end
    end
    checks++; if (!reached) $display("FAIL rst_mid_reach_hi: got %b expected 1", reached); else passes++;
    #1 rst_b = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mid_mem_req: got %b expected 0", bus.mem_req); else passes++;
    checks++; if (bus.cart_data !== 32'h0) $display("FAIL rst_mid_cart_data: got %h expected 00000000", bus.cart_data); else passes++;
    bus.ext_bus_addr = 32'h0800_000C;
    #1;
    checks++; if (bus.cart_wait !== 1'b1) $display("FAIL rst_mid_valid_cleared: got %b expected 1", bus.cart_wait); else passes++;
    bus.cart_rd = 1'b0;
    @(negedge clk);
    rst_b     = 1'b1;
    mem_waits = 0;
    ack_log.delete();
    do_read(32'h0800_0010, BUS_WORD, w, d, r);
    checks++; if (w !== 3) $display("FAIL rst_mid_refetch_wait: got %0d expected 3", w); else passes++;
    checks++; if (d !== 32'hDEAD_BEEF) $display("FAIL rst_mid_refetch_data: got %h expected deadbeef", d); else passes++;
    checks++;
    if (ack_log.size() != 2 || ack_log[0] !== 24'd8 || ack_log[1] !== 24'd9)
      $display("FAIL rst_mid_refetch_addr: got %0d acks first %h expected addresses 8,9", ack_log.size(), ack_log[0]);
    else passes++;
  endtask

`ifdef CART_PREFETCH_EN
  task automatic test_prefetch;
    int w, r; logic [31:0] d;
    bit seen;
    seen = 1'b0;
    ack_log.delete();
    do_read(32'h0800_0000, BUS_WORD, w, d, r);
    checks++; if (w !== 3) $display("FAIL pf_first_wait: got %0d expected 3", w); else passes++;
    checks++; if (d !== 32'hABCD_1234) $display("FAIL pf_first_data: got %h expected abcd1234", d); else passes++;
    repeat (8) @(negedge clk);
    checks++;
    if (ack_log.size() != 4 || ack_log[2] !== 24'd2 || ack_log[3] !== 24'd3)
      $display("FAIL pf_fetch_addr: got %0d acks expected addresses 0,1,2,3", ack_log.size());
    else passes++;
    do_read(32'h0800_0004, BUS_WORD, w, d, r);
    checks++; if (w !== 1) $display("FAIL pf_promote_wait: got %0d expected 1", w); else passes++;
    checks++; if (d !== 32'h7788_5566) $display("FAIL pf_promote_data: got %h expected 77885566", d); else passes++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (bus.mem_req && bus.mem_addr == 24'd4) seen = 1'b1;
    end
    checks++; if (!seen) $display("FAIL pf_next_start: got %b expected 1", seen); else passes++;
  endtask
`endif

  initial begin
    rom[0]  = 16'h1234; rom[1]  = 16'hABCD; rom[2]  = 16'h5566; rom[3]  = 16'h7788;
    rom[4]  = 16'h0F0F; rom[5]  = 16'hC0DE; rom[6]  = 16'h1111; rom[7]  = 16'h2222;
    rom[8]  = 16'hBEEF; rom[9]  = 16'hDEAD; rom[10] = 16'h0A0A; rom[11] = 16'h0B0B;
    rom[12] = 16'h0C0C; rom[13] = 16'h0D0D; rom[14] = 16'h0E0E; rom[15] = 16'h0F00;
    bus.cart_rd       = 1'b0;
    bus.ext_bus_addr  = 32'h0000_0000;
    bus.cart_bus_size = BUS_WORD;

    test_reset();
`ifdef CART_PREFETCH_EN
    test_prefetch();
`else
    test_first_read();
    test_hit();
    test_open_bus();
    test_wait_states();
    test_drop_rd();
    test_stray_ack();
    test_reset_mid_fetch();
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/gba_cart_responder.md
Name: gba_cart_responder

Overview:
- Responder end of the core's cartridge read bus.
- Accepts cart_rd, ext_bus_addr and cart_bus_size from the memory controller. Stalls the core with cart_wait until data is ready, then returns the aligned 32-bit word on cart_data.
- Fetches each word from external 16-bit ROM storage (SDRAM/DDR bridge) through a req/ack handshake, low halfword first.
- Holds the last fetched word so repeated accesses return without a memory transaction.

Parameters:
- ROM_ADDR_W, 25, byte-address width of cartridge ROM (32 MB max).
- ROM_SIZE, 32'h0200_0000, bytes of ROM actually loaded; offsets at or above it read as open bus.

Ports:
- clk  input  1  system clock, same as gba_clk.
- rst_b  input  1  asynchronous active-low reset.
- cart_rd  input  1  read request level; held with address stable until cart_wait is low.
- ext_bus_addr  input  32  byte address; cartridge region 0x0800_0000–0x0DFF_FFFF.
- cart_bus_size  input  2  0=byte, 1=half, 2=word; informational only, a full word is always returned.
- cart_data  output  32  word at {offset[ROM_ADDR_W-1:2],2'b00}.
- cart_wait  output  1  stall request to the core/bus pause logic.
- mem_req  output  1  memory request, held until acked.
- mem_addr  output  ROM_ADDR_W-1  halfword address.
- mem_ack  input  1  one-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  input  16  halfword read data.

Behaviour:
- Reset (async, rst_b low): state IDLE, mem_req=0, mem_addr=0, buffer valid=0, buf_addr=0, buf_data=0, cart_data=0.
- Offset and word address: offset = ext_bus_addr[ROM_ADDR_W-1:0]; waddr = offset[ROM_ADDR_W-1:2]. All three wait-state mirrors alias to the same offset.
- Hit: valid && buf_addr==waddr.
- Open bus: offset >= ROM_SIZE is an immediate hit with no memory access. cart_data = {h+1, h}, where h = offset[16:1] with bit0 cleared, and the 16-bit add wraps.
- cart_wait is combinational: cart_rd && !hit && !open_bus.
- cart_data = buf_data on a hit; open-bus value when out of range; last buf_data otherwise.
- FSM states: IDLE, FETCH_LO, FETCH_HI.
  - IDLE → FETCH_LO when cart_rd and miss. Registers mem_addr = {waddr,1'b0} and asserts mem_req.
  - FETCH_LO: on mem_ack, latch low half, set mem_addr = {waddr,1'b1}, keep mem_req high → FETCH_HI.
  - FETCH_HI: on mem_ack, write buf_data = {mem_rdata, lo}, buf_addr=waddr, valid=1; drop mem_req → IDLE.
- Latency with zero-wait memory (ack the cycle req is seen):
  - cycle 0: cart_rd on a miss, cart_wait=1.
  - cycle 1: lo ack.
  - cycle 2: hi ack.
  - cycle 3: hit, cart_wait=0.
  - Each extra memory wait cycle adds one cycle.
- mem_req and mem_addr change only on clock edges; mem_addr is stable while mem_req is high.
- mem_ack in IDLE is ignored.
- cart_rd dropping mid-fetch: the fetch completes and fills the buffer; no abort.
- Address change mid-fetch is illegal from the core. The responder still completes the latched word, then re-evaluates.
- Reset mid-fetch: abandons the transaction. The memory bridge must tolerate a dropped mem_req.
- No writes: cart_rd only. Writes to cartridge space never reach this block.

Optional Feature:
- CART_PREFETCH_EN defined: adds a second word buffer.
  - After any fill, when IDLE and no miss is pending, fetch waddr+1 (wrapping within ROM_ADDR_W) into the prefetch buffer.
  - A request hitting the prefetch buffer promotes it to the main buffer in one cycle (cart_wait=1 that cycle) and starts the next prefetch.
  - A demand miss during a prefetch waits for the current halfword ack. It then aborts the prefetch, unless the demand address equals the prefetch address, in which case the prefetch continues as the demand fetch.
  - Prefetch never targets offsets >= ROM_SIZE.
- Undefined: single buffer only, behaviour exactly as above.

Decomposition:
- Package gba_cart_pkg: state enum (IDLE, FETCH_LO, FETCH_HI, plus PREFETCH under the macro), bus-size enum, CART_BASE 0x0800_0000, CART_END 0x0DFF_FFFF.
- Sub-module cart_word_buffer: holds addr/data/valid with compare; instantiated once, or twice under CART_PREFETCH_EN.

Test Plan:
- Reset, then word read of 0x0800_0000; memory returns 0x1234 then 0xABCD with zero wait → mem_addr 0 then 1, cart_wait high exactly 3 cycles, cart_data 0xABCD1234.
- Immediate re-read of 0x0800_0002 with size=half → hit, cart_wait never asserted, no mem_req.
- ROM_SIZE=0x100, read 0x0800_0200 → no mem_req, cart_wait=0, cart_data 0x0101_0100.
- Memory acks after 4 waits each half → cart_wait high 11 cycles; mem_addr stable while mem_req is high.
- rst_b low during FETCH_HI → mem_req=0 and valid=0 immediately; next read of the same address refetches both halves.
- CART_PREFETCH_EN: read 0x0800_0000 then 0x0800_0004 after prefetch completes → second read stalls 1 cycle, and a prefetch of waddr 2 starts.
